// File: rtl/pipe_hazard_ctrl.sv
// Hazard scheduler for the five-stage core: sequences decode freeze, bubble insertion,
// redirect flushes and CSR ordering stalls, and keeps saturating stall/flush event counters.
module pipe_hazard_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             id_inst_vld,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_rs1_ren,
    input  logic             id_rs2_ren,
    input  logic             id_is_csr,
    input  logic [4:0]       ex_rd,
    input  logic             ex_rd_wen,
    input  logic             ex_is_load,
    input  logic             ex_is_csr,
    input  logic             csr_wb_done,
    input  logic             ex_redirect,
    input  logic             mem_busy,
    input  logic             cnt_clr,
    output logic             dec_freeze,
    output logic             nop_insert,
    output logic             alu_flush,
    output logic             csr_hazard,
    output logic             if_stall,
    output logic [1:0]       ctl_state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    // state    | meaning
    // IDLE     | normal flow; load-use bubbles and CSR entry decided here
    // FLUSH    | alu_flush held for the remainder of a redirect window
    // CSR_WAIT | decode holds a CSR op until the older CSR write commits
    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_FLUSH    = 2'd1,
        S_CSR_WAIT = 2'd2
    } state_t;

    localparam logic [3:0]       FLUSH_INIT = 4'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    state_t     state, state_nxt;
    logic [3:0] flush_left, flush_left_nxt;
    logic       load_use, csr_entry, stall_ev;

    assign load_use  = id_inst_vld & ex_is_load & ex_rd_wen & (ex_rd != 5'd0) &
                       ((id_rs1_ren & (id_rs1 == ex_rd)) | (id_rs2_ren & (id_rs2 == ex_rd)));
    assign csr_entry = id_inst_vld & id_is_csr & ex_is_csr;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= S_IDLE;
            flush_left <= 4'd0;
        end else begin
            state      <= state_nxt;
            flush_left <= flush_left_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        flush_left_nxt = flush_left;
        if (ex_redirect) begin
            // a redirect restarts the flush window and abandons any CSR wait
            if (FLUSH_CYCLES > 1) begin
                state_nxt      = S_FLUSH;
                flush_left_nxt = FLUSH_INIT;
            end else begin
                state_nxt      = S_IDLE;
                flush_left_nxt = 4'd0;
            end
        end else if (state == S_FLUSH) begin
            flush_left_nxt = flush_left - 4'd1;
            if (flush_left == 4'd1) begin
                state_nxt = S_IDLE;
            end
        end else if (state == S_CSR_WAIT) begin
            if (csr_wb_done) begin
                state_nxt = S_IDLE;
            end
        end else if (!mem_busy && csr_entry && !csr_wb_done) begin
            state_nxt = S_CSR_WAIT;
        end
    end

    always_comb begin
        alu_flush  = 1'b0;
        dec_freeze = 1'b0;
        nop_insert = 1'b0;
        csr_hazard = 1'b0;
        if_stall   = 1'b0;
        if (RST) begin
            alu_flush = 1'b0;
        end else if (ex_redirect || state == S_FLUSH) begin
            alu_flush = 1'b1;
        end else if (mem_busy) begin
            dec_freeze = 1'b1;
            if_stall   = 1'b1;
            csr_hazard = (state == S_CSR_WAIT);
        end else if (state == S_CSR_WAIT || csr_entry) begin
            csr_hazard = 1'b1;
            if_stall   = 1'b1;
        end else if (load_use) begin
            nop_insert = 1'b1;
            if_stall   = 1'b1;
        end
    end

    assign ctl_state = state;
    assign stall_ev  = dec_freeze | nop_insert | csr_hazard;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (cnt_clr) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_ev && stall_cnt != CNT_MAX) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (ex_redirect && flush_cnt != CNT_MAX) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed and randomized checks of pipe_hazard_ctrl against a cycle-level reference
// model that tracks remaining flush cycles and a pending-CSR flag.
module tb_pipe_hazard_ctrl;
    localparam int FC   = 2;
    localparam int CW   = 4;
    localparam int CMAX = 15;

    logic          CLK = 1'b0;
    logic          RST;
    logic          id_inst_vld, id_rs1_ren, id_rs2_ren, id_is_csr;
    logic [4:0]    id_rs1, id_rs2, ex_rd;
    logic          ex_rd_wen, ex_is_load, ex_is_csr, csr_wb_done;
    logic          ex_redirect, mem_busy, cnt_clr;
    logic          dec_freeze, nop_insert, alu_flush, csr_hazard, if_stall;
    logic [1:0]    ctl_state;
    logic [CW-1:0] stall_cnt, flush_cnt;

    pipe_hazard_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
        .CLK(CLK), .RST(RST),
        .id_inst_vld(id_inst_vld), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_ren(id_rs1_ren), .id_rs2_ren(id_rs2_ren), .id_is_csr(id_is_csr),
        .ex_rd(ex_rd), .ex_rd_wen(ex_rd_wen), .ex_is_load(ex_is_load),
        .ex_is_csr(ex_is_csr), .csr_wb_done(csr_wb_done), .ex_redirect(ex_redirect),
        .mem_busy(mem_busy), .cnt_clr(cnt_clr),
        .dec_freeze(dec_freeze), .nop_insert(nop_insert), .alu_flush(alu_flush),
        .csr_hazard(csr_hazard), .if_stall(if_stall), .ctl_state(ctl_state),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // model: cycles of alu_flush still owed after this one, and whether a CSR op is parked
    int m_flush_rem;
    bit m_csr;
    int m_stall, m_flush;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_in();
        id_inst_vld = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_ren = 0; id_rs2_ren = 0;
        id_is_csr = 0; ex_rd = 0; ex_rd_wen = 0; ex_is_load = 0; ex_is_csr = 0;
        csr_wb_done = 0; ex_redirect = 0; mem_busy = 0; cnt_clr = 0;
    endtask

    task automatic model_reset();
        m_flush_rem = 0; m_csr = 0; m_stall = 0; m_flush = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_alu_flush"}, 32'(alu_flush), 0);
        chk({tag, "_dec_freeze"}, 32'(dec_freeze), 0);
        chk({tag, "_nop_insert"}, 32'(nop_insert), 0);
        chk({tag, "_csr_hazard"}, 32'(csr_hazard), 0);
        chk({tag, "_if_stall"}, 32'(if_stall), 0);
        chk({tag, "_state"}, 32'(ctl_state), 0);
        chk({tag, "_stall_cnt"}, 32'(stall_cnt), 0);
        chk({tag, "_flush_cnt"}, 32'(flush_cnt), 0);
    endtask

    // one clock: compare at negedge against the model, then advance the model
    task automatic step();
        bit lu, ce, e_alu, e_frz, e_nop, e_csr, e_ifs;
        int e_st;
        @(negedge CLK);
        lu = id_inst_vld && ex_is_load && ex_rd_wen && (ex_rd != 0) &&
             ((id_rs1_ren && id_rs1 == ex_rd) || (id_rs2_ren && id_rs2 == ex_rd));
        ce = id_inst_vld && id_is_csr && ex_is_csr;
        e_alu = 0; e_frz = 0; e_nop = 0; e_csr = 0; e_ifs = 0;
        if (ex_redirect || m_flush_rem > 0) e_alu = 1;
        else if (mem_busy) begin e_frz = 1; e_ifs = 1; e_csr = m_csr; end
        else if (m_csr || ce) begin e_csr = 1; e_ifs = 1; end
        else if (lu) begin e_nop = 1; e_ifs = 1; end
        e_st = (m_flush_rem > 0) ? 1 : (m_csr ? 2 : 0);

        chk("alu_flush", 32'(alu_flush), 32'(e_alu));
        chk("dec_freeze", 32'(dec_freeze), 32'(e_frz));
        chk("nop_insert", 32'(nop_insert), 32'(e_nop));
        chk("csr_hazard", 32'(csr_hazard), 32'(e_csr));
        chk("if_stall", 32'(if_stall), 32'(e_ifs));
        chk("ctl_state", 32'(ctl_state), 32'(e_st));
        chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
        chk("flush_cnt", 32'(flush_cnt), 32'(m_flush));
        chk("excl_ctl", 32'($countones({alu_flush, dec_freeze, nop_insert}) <= 1), 1);

        if (ex_redirect) begin
            m_flush_rem = FC - 1;
            m_csr = 0;
        end else if (m_flush_rem > 0) begin
            m_flush_rem--;
        end else if (m_csr) begin
            if (csr_wb_done) m_csr = 0;
        end else if (!mem_busy && ce && !csr_wb_done) begin
            m_csr = 1;
        end
        if (cnt_clr) begin
            m_stall = 0;
            m_flush = 0;
        end else begin
            if ((e_frz || e_nop || e_csr) && m_stall < CMAX) m_stall++;
            if (ex_redirect && m_flush < CMAX) m_flush++;
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic set_load_use(input logic [4:0] rd);
        id_inst_vld = 1; ex_is_load = 1; ex_rd_wen = 1; ex_rd = rd;
        id_rs2 = 5'd5; id_rs2_ren = 1;
    endtask

    task automatic set_csr_entry();
        id_inst_vld = 1; id_is_csr = 1; ex_is_csr = 1;
    endtask

    initial begin
        int base;
        clear_in();
        model_reset();
        RST = 1;
        ex_redirect = 1; mem_busy = 1;
        #12;
        check_reset_outputs("por");
        @(posedge CLK); #1;
        RST = 0;
        clear_in();

        // load-use bubble, then the same pattern with x0 as destination
        set_load_use(5'd5);
        step();
        clear_in();
        step();
        chk("lu_stall_cnt", 32'(stall_cnt), 1);
        set_load_use(5'd0);
        id_rs2 = 5'd0;
        step();
        clear_in();
        step();
        chk("lu_x0_stall_cnt", 32'(stall_cnt), 1);

        // single redirect, then back-to-back redirects
        ex_redirect = 1; step();
        ex_redirect = 0; step();
        step();
        chk("redir_flush_cnt", 32'(flush_cnt), 1);
        ex_redirect = 1; step();
        step();
        ex_redirect = 0; step();
        step();

        // CSR entry with commit four cycles later
        base = int'(stall_cnt);
        set_csr_entry(); step();
        clear_in(); step(); step(); step();
        csr_wb_done = 1; step();
        csr_wb_done = 0; step();
        chk("csr_stall_delta", 32'(int'(stall_cnt) - base), 5);

        // mem_busy inside CSR_WAIT with commit on the second busy cycle
        set_csr_entry(); step();
        clear_in();
        mem_busy = 1; step();
        csr_wb_done = 1; step();
        csr_wb_done = 0; step();
        mem_busy = 0; step();

        // saturation and clear
        mem_busy = 1;
        repeat (20) step();
        chk("sat_stall_cnt", 32'(stall_cnt), CMAX);
        cnt_clr = 1; step();
        cnt_clr = 0; mem_busy = 0;
        chk("clr_stall_cnt", 32'(stall_cnt), 0);
        step();

        // async reset mid-FLUSH
        ex_redirect = 1; step();
        ex_redirect = 0;
        #2;
        chk("pre_rst_flush_state", 32'(ctl_state), 1);
        RST = 1; ex_redirect = 1;
        #1;
        check_reset_outputs("rst_flush");
        @(posedge CLK); #1;
        RST = 0; clear_in(); model_reset();
        step();

        // async reset mid-CSR_WAIT
        set_csr_entry(); step();
        clear_in(); step();
        #2;
        chk("pre_rst_csr_state", 32'(ctl_state), 2);
        RST = 1; set_csr_entry(); mem_busy = 1;
        #1;
        check_reset_outputs("rst_csr");
        @(posedge CLK); #1;
        RST = 0; clear_in(); model_reset();
        ex_redirect = 1; step();
        ex_redirect = 0; step();
        step();

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            id_inst_vld = ($urandom_range(0, 3) != 0);
            id_rs1      = 5'($urandom_range(0, 3));
            id_rs2      = 5'($urandom_range(0, 3));
            id_rs1_ren  = 1'($urandom_range(0, 1));
            id_rs2_ren  = 1'($urandom_range(0, 1));
            id_is_csr   = ($urandom_range(0, 3) == 0);
            ex_rd       = 5'($urandom_range(0, 3));
            ex_rd_wen   = ($urandom_range(0, 3) != 0);
            ex_is_load  = ($urandom_range(0, 2) == 0);
            ex_is_csr   = ($urandom_range(0, 2) == 0);
            csr_wb_done = ($urandom_range(0, 5) == 0);
            ex_redirect = ($urandom_range(0, 9) == 0);
            mem_busy    = ($urandom_range(0, 4) == 0);
            cnt_clr     = ($urandom_range(0, 59) == 0);
            step();
        end
        clear_in();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
